// File: rtl/mips_register_file_sb.sv
// mips_register_file_sb
//   Parametrised MIPS register file with a per-register busy scoreboard.
//   Decode reads two registers and marks load destinations busy.
//   Writeback writes one register and clears its busy bit.
//
// Parameters
//   DATA_WIDTH     bits per register
//   REG_ADDR_WIDTH register address bits, NUM_REGS = 2**REG_ADDR_WIDTH
//   ZERO_REG       1: register 0 reads 0, ignores writes and is never busy
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN)
//   When defined, a write in the current cycle is forwarded to a read port
//   that addresses the same register.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   read_reg_1/2                  read addresses
//   read_data_1/2, read_busy_1/2  combinational read data and busy bits
//   write_reg, write_data         writeback address and data
//   signal_reg_write              write enable; also clears busy[write_reg]
//   set_busy, set_busy_reg        mark a register as having a load in flight
//   busy_count                    registered number of busy registers
module mips_register_file_sb #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 3,
  parameter int unsigned ZERO_REG       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] read_reg_1,
  input  logic [REG_ADDR_WIDTH-1:0] read_reg_2,
  input  logic [REG_ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0]     write_data,
  input  logic                      signal_reg_write,
  input  logic                      set_busy,
  input  logic [REG_ADDR_WIDTH-1:0] set_busy_reg,
  output logic [DATA_WIDTH-1:0]     read_data_1,
  output logic [DATA_WIDTH-1:0]     read_data_2,
  output logic                      read_busy_1,
  output logic                      read_busy_2,
  output logic [REG_ADDR_WIDTH:0]   busy_count
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;
  localparam int unsigned CNT_W    = REG_ADDR_WIDTH + 1;
  localparam bit          HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [CNT_W-1:0]      busy_count_q;
  logic [CNT_W-1:0]      busy_count_d;

  logic wr_en_c;
  logic set_en_c;
  logic same_reg_c;
  logic rise_c;
  logic fall_c;

  // Qualified enables: the hardwired zero register takes no writes or busy marks
  assign wr_en_c    = signal_reg_write && !(HAS_ZERO && (write_reg == '0));
  assign set_en_c   = set_busy && !(HAS_ZERO && (set_busy_reg == '0));
  assign same_reg_c = (set_busy_reg == write_reg);

  // Next busy vector: clear on writeback first, so a same-register set wins
  always_comb begin
    busy_d = busy_q;
    if (signal_reg_write) begin
      busy_d[write_reg] = 1'b0;
    end
    if (set_en_c) begin
      busy_d[set_busy_reg] = 1'b1;
    end
  end

  // Counter deltas track real bit transitions only
  assign rise_c = set_en_c && !busy_q[set_busy_reg];
  assign fall_c = signal_reg_write && busy_q[write_reg] && !(set_en_c && same_reg_c);

  assign busy_count_d = busy_count_q + CNT_W'(rise_c) - CNT_W'(fall_c);

  // Register storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[write_reg] <= write_data;
    end
  end

  // Busy scoreboard and its population counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  // Read port 1
  always_comb begin
    read_data_1 = regs_q[read_reg_1];
    read_busy_1 = busy_q[read_reg_1];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_c && (read_reg_1 == write_reg)) begin
      read_data_1 = write_data;
      read_busy_1 = set_en_c && same_reg_c;
    end
`endif
    if (HAS_ZERO && (read_reg_1 == '0)) begin
      read_data_1 = '0;
      read_busy_1 = 1'b0;
    end
  end

  // Read port 2
  always_comb begin
    read_data_2 = regs_q[read_reg_2];
    read_busy_2 = busy_q[read_reg_2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_c && (read_reg_2 == write_reg)) begin
      read_data_2 = write_data;
      read_busy_2 = set_en_c && same_reg_c;
    end
`endif
    if (HAS_ZERO && (read_reg_2 == '0)) begin
      read_data_2 = '0;
      read_busy_2 = 1'b0;
    end
  end

endmodule
